// File: rtl/tmr_pkg.sv
// Shared constants and slice helper for the triple-modular-redundancy voting pipeline.
package tmr_pkg;

    localparam int NUM_COPIES = 3;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 8;

    // LSB position of copy k inside a packed {copy2, copy1, copy0} word of w-bit copies.
    function automatic int copy_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/tmr_voter.sv
// Combinational bitwise 2-of-3 voter with per-copy disagreement and multi-copy flags.
module tmr_voter
    import tmr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [NUM_COPIES*DATA_W-1:0] copies,
    output logic [DATA_W-1:0]            maj,
    output logic [NUM_COPIES-1:0]        err_copy,
    output logic                         multi
);

    logic [NUM_COPIES-1:0][DATA_W-1:0] cp_s;
    logic [DATA_W-1:0]                 maj_s;
    logic [NUM_COPIES-1:0]             err_s;
    logic                              multi_s;

    // Split the packed word, vote per bit, then flag every copy that lost any bit.
    always_comb begin
        cp_s = '0;
        for (int k = 0; k < NUM_COPIES; k++) begin
            cp_s[k] = copies[copy_lsb(k, DATA_W) +: DATA_W];
        end
        maj_s = (cp_s[0] & cp_s[1]) | (cp_s[0] & cp_s[2]) | (cp_s[1] & cp_s[2]);
        err_s = '0;
        for (int k = 0; k < NUM_COPIES; k++) begin
            err_s[k] = |(cp_s[k] ^ maj_s);
        end
        // Two losing copies means the vote itself may have been wrong.
        multi_s = (err_s[0] & err_s[1]) | (err_s[0] & err_s[2]) | (err_s[1] & err_s[2]);
    end

    assign maj      = maj_s;
    assign err_copy = err_s;
    assign multi    = multi_s;

endmodule

// File: rtl/tmr_vote_pipe.sv
// Two-stage valid/ready pipeline around tmr_voter with saturating per-copy and multi-fault counters.
module tmr_vote_pipe
    import tmr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_COPIES*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [NUM_COPIES-1:0]        out_err_copy,
    output logic                         out_multi,
    input  logic                         cnt_clr,
    output logic [NUM_COPIES*CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]             multi_cnt
);

    logic                              s1_valid_r;
    logic [NUM_COPIES*DATA_W-1:0]      s1_data_r;
    logic                              s2_valid_r;
    logic [DATA_W-1:0]                 s2_data_r;
    logic [NUM_COPIES-1:0]             s2_err_r;
    logic                              s2_multi_r;
    logic [NUM_COPIES-1:0][CNT_W-1:0]  err_cnt_r;
    logic [CNT_W-1:0]                  multi_cnt_r;

    logic                              s2_free_s;
    logic                              s1_adv_s;
    logic                              in_fire_s;
    logic                              in_ready_s;
    logic [DATA_W-1:0]                 maj_s;
    logic [NUM_COPIES-1:0]             err_s;
    logic                              multi_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    tmr_voter #(
        .DATA_W (DATA_W)
    ) u_voter (
        .copies   (s1_data_r),
        .maj      (maj_s),
        .err_copy (err_s),
        .multi    (multi_s)
    );

    // Handshake decode; in_ready depends only on stage state and out_ready.
    always_comb begin
        s2_free_s  = !s2_valid_r || out_ready;
        s1_adv_s   = s1_valid_r && s2_free_s;
        in_ready_s = !s1_valid_r || s2_free_s;
        in_fire_s  = in_valid && in_ready_s;
    end

    // Stage 1: capture the raw triple-copy word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_data_r  <= in_data;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: register the vote result; contents hold while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
            s2_err_r   <= '0;
            s2_multi_r <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_r <= 1'b1;
            s2_data_r  <= maj_s;
            s2_err_r   <= err_s;
            s2_multi_r <= multi_s;
        end else if (out_ready) begin
            s2_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Fault counters bump on each S1->S2 load; a clear on the same edge takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            err_cnt_r   <= '0;
            multi_cnt_r <= '0;
        end else if (s1_adv_s) begin
            for (int k = 0; k < NUM_COPIES; k++) begin
                if (err_s[k]) begin
                    err_cnt_r[k] <= sat_inc(err_cnt_r[k]);
                end else begin
                    err_cnt_r[k] <= err_cnt_r[k];
                end
            end
            if (multi_s) begin
                multi_cnt_r <= sat_inc(multi_cnt_r);
            end else begin
                multi_cnt_r <= multi_cnt_r;
            end
        end else begin
            err_cnt_r   <= err_cnt_r;
            multi_cnt_r <= multi_cnt_r;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = s2_valid_r;
    assign out_data     = s2_data_r;
    assign out_err_copy = s2_err_r;
    assign out_multi    = s2_multi_r;
    assign err_cnt      = err_cnt_r;
    assign multi_cnt    = multi_cnt_r;

endmodule

// File: tb/tb_tmr_vote_pipe.sv
// Self-checking bench for tmr_vote_pipe: vector table plus scoreboard and hand-written corner sequences.
module tb_tmr_vote_pipe;

    localparam int DW = 16;
    localparam int CW = 2;

    typedef struct {
        logic [DW-1:0] c0;
        logic [DW-1:0] c1;
        logic [DW-1:0] c2;
        logic [DW-1:0] data;
        logic [2:0]    err;
        logic          multi;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_err_copy;
    logic            out_multi;
    logic            cnt_clr;
    logic [3*CW-1:0] err_cnt;
    logic [CW-1:0]   multi_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t cur;
    bit   acc;
    vec_t exp_q[$];
    vec_t tbl[7];

    tmr_vote_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err_copy (out_err_copy),
        .out_multi    (out_multi),
        .cnt_clr      (cnt_clr),
        .err_cnt      (err_cnt),
        .multi_cnt    (multi_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                input logic [DW-1:0] c2, input logic [DW-1:0] d,
                                input logic [2:0] e, input logic m);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.c2 = c2; v.data = d; v.err = e; v.multi = m;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic drive(input vec_t v);
        cur      = v;
        in_data  = {v.c2, v.c1, v.c0};
        in_valid = 1'b1;
    endtask

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic cycle();
        vec_t e;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got data 0x%0h expected no word", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_err_copy", out_err_copy, e.err);
                check("out_multi", out_multi, e.multi);
            end
        end
        acc = in_valid && (in_ready === 1'b1);
        if (acc) exp_q.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input vec_t v);
        int t = 0;
        drive(v);
        do begin
            cycle();
            t++;
        end while (!acc && t < 20);
        in_valid = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic drain();
        int t = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && t < 50) begin
            cycle();
            t++;
        end
        check("drain_left", exp_q.size(), 0);
        cycle();
    endtask

    task automatic clr_cnt();
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        cycle();
        cnt_clr  = 1'b0;
    endtask

    initial begin
        int   ecnt[3];
        int   mcnt;
        int   n_acc;
        int   w;
        bit   have;
        logic [DW-1:0] held;
        vec_t f;

        tbl[0] = mk(16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 3'b000, 1'b0);
        tbl[1] = mk(16'hA5C3, 16'hA5C2, 16'hA5C3, 16'hA5C3, 3'b010, 1'b0);
        tbl[2] = mk(16'h0001, 16'h0000, 16'h0020, 16'h0000, 3'b101, 1'b1);
        tbl[3] = mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 3'b001, 1'b0);
        tbl[4] = mk(16'h1234, 16'h1234, 16'hEDCB, 16'h1234, 3'b100, 1'b0);
        tbl[5] = mk(16'h00FF, 16'h0F0F, 16'h3333, 16'h033F, 3'b111, 1'b1);
        tbl[6] = mk(16'h8000, 16'h8000, 16'h0000, 16'h8000, 3'b100, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; in_data = '0;
        cur = tbl[0];
        repeat (3) cycle();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err_copy, 0);
        check("rst_out_multi", out_multi, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_multi_cnt", multi_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        cycle();
        check("post_rst_in_ready", in_ready, 1);

        // Clean word and two-cycle latency.
        drive(tbl[0]);
        cycle();
        in_valid = 1'b0;
        check("lat_accept", acc, 1);
        check("lat_cycle1_valid", out_valid, 0);
        cycle();
        check("lat_cycle2_valid", out_valid, 1);
        check("lat_cycle2_data", out_data, 16'hA5C3);
        drain();
        check("clean_err_cnt", err_cnt, 0);
        check("clean_multi_cnt", multi_cnt, 0);

        // Single-copy fault on copy1.
        clr_cnt();
        send_one(tbl[1]);
        drain();
        check("single_err_cnt", err_cnt, 6'b00_01_00);
        check("single_multi_cnt", multi_cnt, 0);

        // Two copies faulty on different bits.
        clr_cnt();
        send_one(tbl[2]);
        drain();
        check("multi_err_cnt", err_cnt, 6'b01_00_01);
        check("multi_multi_cnt", multi_cnt, 1);

        // Whole table back-to-back at full throughput.
        clr_cnt();
        ecnt = '{0, 0, 0};
        mcnt = 0;
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            cycle();
            check("tput_accept", acc, 1);
            for (int k = 0; k < 3; k++)
                if (tbl[i].err[k] && ecnt[k] < 3) ecnt[k]++;
            if (tbl[i].multi && mcnt < 3) mcnt++;
        end
        drain();
        check("tbl_err_cnt0", err_cnt[1:0], ecnt[0]);
        check("tbl_err_cnt1", err_cnt[3:2], ecnt[1]);
        check("tbl_err_cnt2", err_cnt[5:4], ecnt[2]);
        check("tbl_multi_cnt", multi_cnt, mcnt);

        // Backpressure: stall 5 cycles with a continuous input stream.
        out_ready = 1'b0;
        w = 0; n_acc = 0; have = 1'b0; held = '0;
        for (int i = 0; i < 5; i++) begin
            f = mk(16'h0100 + w[15:0], 16'h0100 + w[15:0], 16'h0100 + w[15:0],
                   16'h0100 + w[15:0], 3'b000, 1'b0);
            drive(f);
            cycle();
            if (acc) begin n_acc++; w++; end
            if (out_valid) begin
                if (!have) begin held = out_data; have = 1'b1; end
                else check("bp_hold", out_data, held);
            end
        end
        check("bp_accepted", n_acc, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_first_word", held, 16'h0100);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            f = mk(16'h0100 + w[15:0], 16'h0100 + w[15:0], 16'h0100 + w[15:0],
                   16'h0100 + w[15:0], 3'b000, 1'b0);
            drive(f);
            cycle();
            if (acc) w++;
        end
        drain();
        check("bp_total_words", w, 8);

        // Saturation at 3, then clear colliding with an increment.
        clr_cnt();
        f = mk(16'h0001, 16'h0000, 16'h0000, 16'h0000, 3'b001, 1'b0);
        for (int i = 0; i < 5; i++) send_one(f);
        drain();
        check("sat_err_cnt", err_cnt, 6'b00_00_11);
        drive(f);
        cycle();
        check("clr_accept", acc, 1);
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        cycle();
        cnt_clr  = 1'b0;
        check("clr_wins", err_cnt, 0);
        drain();
        check("clr_after_drain", err_cnt, 0);

        // Reset with both stages full.
        clr_cnt();
        out_ready = 1'b0;
        drive(f);
        cycle();
        cycle();
        in_valid = 1'b0;
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_err_cnt", err_cnt, 6'b00_00_01);
        rst_n = 1'b0;
        cycle();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_multi_cnt", multi_cnt, 0);
        check("mid_rst_out_data", out_data, 0);
        exp_q.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("post_rst_no_output", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
